// File: rtl/lbr_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : lbr_trace_buffer
//  Description : Last-branch-record buffer. Retired taken control transfers
//                (from PC / to PC) are captured into a circular store of
//                LBR_SIZE entries, with per-type filtering, an occupancy
//                count, freeze-on-full, a wrap interrupt and a registered
//                CSR read/write port.
//
//  Ports       : clock, reset      - single clock, synchronous active-high reset
//                stall             - pipeline stall, suppresses recording
//                branch_valid/type - retiring taken transfer and its kind
//                from_pc, to_pc    - transfer source and target PCs
//                csr_read/write    - CSR access strobes (write wins if both)
//                csr_addr/wdata    - CSR register select and write data
//                csr_rdata/rvalid  - registered read data, one-cycle valid
//                lbr_irq           - level interrupt (irq_en & wrapped)
//
//  Options     : `define LBR_CYCLE_STAMP_EN adds a free-running cycle counter
//                and a per-entry STAMP array readable/writable at {11,i}.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module lbr_trace_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int LBR_SIZE     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          branch_valid,
    input  logic [1:0]                    branch_type,
    input  logic [ADDRESS_BITS-1:0]       from_pc,
    input  logic [ADDRESS_BITS-1:0]       to_pc,
    input  logic                          csr_read,
    input  logic                          csr_write,
    input  logic [$clog2(LBR_SIZE)+1:0]   csr_addr,
    input  logic [DATA_WIDTH-1:0]         csr_wdata,
    output logic [DATA_WIDTH-1:0]         csr_rdata,
    output logic                          csr_rvalid,
    output logic                          lbr_irq
);

    localparam int c_IDX_W  = $clog2(LBR_SIZE);
    localparam int c_ADDR_W = c_IDX_W + 2;
    localparam int c_CNT_W  = c_IDX_W + 1;

    localparam logic [1:0] c_SEL_FROM  = 2'b00;
    localparam logic [1:0] c_SEL_TO    = 2'b01;
    localparam logic [1:0] c_SEL_REG   = 2'b10;

    localparam logic [c_IDX_W-1:0] c_REG_TOS    = c_IDX_W'(0);
    localparam logic [c_IDX_W-1:0] c_REG_CTRL   = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_REG_STATUS = c_IDX_W'(2);

    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(LBR_SIZE);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(LBR_SIZE - 1);

    // CTRL bit positions
    localparam int c_CTRL_EN     = 0;
    localparam int c_CTRL_JAL    = 1;
    localparam int c_CTRL_JALR   = 2;
    localparam int c_CTRL_COND   = 3;
    localparam int c_CTRL_FREEZE = 4;
    localparam int c_CTRL_IRQEN  = 5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_from [LBR_SIZE];
    logic [DATA_WIDTH-1:0] r_to   [LBR_SIZE];
    logic [c_IDX_W-1:0]    r_tos;
    logic [5:0]            r_ctrl;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_wrapped;
    logic                  r_frozen;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_irq;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [1:0]            w_sel;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_csr_rd;
    logic                  w_wr_from;
    logic                  w_wr_to;
    logic                  w_wr_tos;
    logic                  w_wr_ctrl;
    logic                  w_wr_status;
    logic                  w_type_ok;
    logic                  w_record;
    logic [c_IDX_W-1:0]    w_tos_inc;
    logic [DATA_WIDTH-1:0] w_from_ext;
    logic [DATA_WIDTH-1:0] w_to_ext;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    assign w_sel      = csr_addr[c_ADDR_W-1:c_IDX_W];
    assign w_idx      = csr_addr[c_IDX_W-1:0];
    // A write on the same cycle as a read suppresses the read entirely.
    assign w_csr_rd   = csr_read & ~csr_write;

    assign w_wr_from   = csr_write && (w_sel == c_SEL_FROM);
    assign w_wr_to     = csr_write && (w_sel == c_SEL_TO);
    assign w_wr_tos    = csr_write && (w_sel == c_SEL_REG) && (w_idx == c_REG_TOS);
    assign w_wr_ctrl   = csr_write && (w_sel == c_SEL_REG) && (w_idx == c_REG_CTRL);
    assign w_wr_status = csr_write && (w_sel == c_SEL_REG) && (w_idx == c_REG_STATUS);

    always_comb begin
        w_type_ok = 1'b0;
        case (branch_type)
            2'b00:   w_type_ok = r_ctrl[c_CTRL_JAL];
            2'b01:   w_type_ok = r_ctrl[c_CTRL_JALR];
            2'b10:   w_type_ok = r_ctrl[c_CTRL_COND];
            default: w_type_ok = 1'b0;
        endcase
    end

    assign w_record   = branch_valid & ~stall & r_ctrl[c_CTRL_EN] & w_type_ok & ~r_frozen;
    // Power-of-two size: the natural index overflow is the modulo wrap.
    assign w_tos_inc  = r_tos + c_IDX_W'(1);
    assign w_from_ext = DATA_WIDTH'(from_pc);
    assign w_to_ext   = DATA_WIDTH'(to_pc);

    // ------------------------------------------------------------------
    // Entry storage. The record assignment comes last so that it wins a
    // same-index collision with a CSR restore.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LBR_SIZE; i++) begin
                r_from[i] <= '0;
                r_to[i]   <= '0;
            end
        end else begin
            if (w_wr_from) r_from[w_idx] <= csr_wdata;
            if (w_wr_to)   r_to[w_idx]   <= csr_wdata;
            if (w_record) begin
                r_from[w_tos_inc] <= w_from_ext;
                r_to[w_tos_inc]   <= w_to_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control / status. CSR writes to TOS and STATUS are placed after the
    // record updates so that software wins those races.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tos     <= '1;
            r_ctrl    <= 6'h0F;
            r_count   <= '0;
            r_wrapped <= 1'b0;
            r_frozen  <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= r_ctrl[c_CTRL_IRQEN] & r_wrapped;

            if (w_record) r_tos <= w_tos_inc;
            if (w_wr_tos) r_tos <= csr_wdata[c_IDX_W-1:0];

            if (w_wr_ctrl) r_ctrl <= csr_wdata[5:0];

            if (w_record && (r_count != c_FULL)) begin
                r_count <= r_count + c_CNT_W'(1);
                if (r_count == c_FULL_M1) begin
                    r_wrapped <= 1'b1;
                    if (r_ctrl[c_CTRL_FREEZE]) r_frozen <= 1'b1;
                end
            end

            if (w_wr_status) begin
                r_count   <= '0;
                r_wrapped <= 1'b0;
                r_frozen  <= 1'b0;
            end
        end
    end

`ifdef LBR_CYCLE_STAMP_EN
    logic [DATA_WIDTH-1:0] r_cycle;
    logic [DATA_WIDTH-1:0] r_stamp [LBR_SIZE];
    logic                  w_wr_stamp;

    assign w_wr_stamp = csr_write && (w_sel == 2'b11);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle <= '0;
            for (int i = 0; i < LBR_SIZE; i++) begin
                r_stamp[i] <= '0;
            end
        end else begin
            r_cycle <= r_cycle + DATA_WIDTH'(1);
            if (w_wr_stamp) r_stamp[w_idx] <= csr_wdata;
            if (w_record)   r_stamp[w_tos_inc] <= r_cycle;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read path: the mux sees pre-edge state, so a read returns the value
    // as it stood before any same-edge update.
    // ------------------------------------------------------------------
    always_comb begin
        w_status                = '0;
        w_status[c_CNT_W-1:0]   = r_count;
        w_status[16]            = r_wrapped;
        w_status[17]            = r_frozen;
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            c_SEL_FROM: w_rd_mux = r_from[w_idx];
            c_SEL_TO:   w_rd_mux = r_to[w_idx];
            c_SEL_REG: begin
                case (w_idx)
                    c_REG_TOS:    w_rd_mux = DATA_WIDTH'(r_tos);
                    c_REG_CTRL:   w_rd_mux = DATA_WIDTH'(r_ctrl);
                    c_REG_STATUS: w_rd_mux = w_status;
                    default:      w_rd_mux = '0;
                endcase
            end
            default: begin
`ifdef LBR_CYCLE_STAMP_EN
                w_rd_mux = r_stamp[w_idx];
`else
                w_rd_mux = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_csr_rd;
            if (w_csr_rd) r_rdata <= w_rd_mux;
        end
    end

    assign csr_rdata  = r_rdata;
    assign csr_rvalid = r_rvalid;
    assign lbr_irq    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_lbr_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lbr_trace_buffer
//  Description : Self-checking bench for lbr_trace_buffer (default sizes:
//                DATA_WIDTH=32, ADDRESS_BITS=20, LBR_SIZE=16). A table of
//                single-cycle vectors covers reset state, recording and
//                filtering; hand-written sequences cover freeze/wrap/irq,
//                same-edge races and reset during a record.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lbr_trace_buffer;

    localparam int c_OP_IDLE = 0;
    localparam int c_OP_REC  = 1;
    localparam int c_OP_WR   = 2;
    localparam int c_OP_RD   = 3;

    localparam logic [5:0] c_A_FROM   = 6'h00;
    localparam logic [5:0] c_A_TO     = 6'h10;
    localparam logic [5:0] c_A_TOS    = 6'h20;
    localparam logic [5:0] c_A_CTRL   = 6'h21;
    localparam logic [5:0] c_A_STATUS = 6'h22;
    localparam logic [5:0] c_A_STAMP  = 6'h30;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic [1:0]  branch_type = 2'b00;
    logic [19:0] from_pc = '0;
    logic [19:0] to_pc = '0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [5:0]  csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        lbr_irq;

    int tests = 0;
    int fails = 0;

    lbr_trace_buffer #(
        .DATA_WIDTH  (32),
        .ADDRESS_BITS(20),
        .LBR_SIZE    (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .branch_valid(branch_valid),
        .branch_type (branch_type),
        .from_pc     (from_pc),
        .to_pc       (to_pc),
        .csr_read    (csr_read),
        .csr_write   (csr_write),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_rvalid  (csr_rvalid),
        .lbr_irq     (lbr_irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          op;
        logic [1:0]  bt;
        logic        st;
        logic [19:0] fpc;
        logic [19:0] tpc;
        logic [5:0]  addr;
        logic [31:0] dat;   // write data for WR, expected rdata for RD
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int op, input logic [1:0] bt, input logic st,
                                input logic [19:0] f, input logic [19:0] t,
                                input logic [5:0] a, input logic [31:0] d);
        vec_t v;
        v.op = op; v.bt = bt; v.st = st; v.fpc = f; v.tpc = t; v.addr = a; v.dat = d;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        stall        = 1'b0;
        branch_valid = 1'b0;
        branch_type  = 2'b00;
        from_pc      = '0;
        to_pc        = '0;
        csr_read     = 1'b0;
        csr_write    = 1'b0;
        csr_addr     = '0;
        csr_wdata    = '0;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string nm);
        csr_read = 1'b1;
        csr_addr = a;
        step();
        clear_inputs();
        check({nm, " rvalid"}, 32'(csr_rvalid), 32'd1);
        check(nm, csr_rdata, exp);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        csr_write = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        step();
        clear_inputs();
    endtask

    task automatic rec(input logic [1:0] bt, input logic [19:0] f, input logic [19:0] t);
        branch_valid = 1'b1;
        branch_type  = bt;
        from_pc      = f;
        to_pc        = t;
        step();
        clear_inputs();
    endtask

    initial begin
        // ---------------- vector table ----------------
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_TOS,       32'hF));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_CTRL,      32'h0F));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_STATUS,    32'h0));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_FROM,      32'h0));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_TO,        32'h0));
        vecs.push_back(mk(c_OP_REC,  0, 0, 20'h00100, 20'h00200, 0, 0));
        vecs.push_back(mk(c_OP_REC,  1, 0, 20'h00204, 20'h00300, 0, 0));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_TOS,       32'h1));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_FROM + 0,  32'h100));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_TO + 0,    32'h200));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_FROM + 1,  32'h204));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_TO + 1,    32'h300));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_STATUS,    32'h2));
        vecs.push_back(mk(c_OP_WR,   0, 0, 0, 0, c_A_CTRL,      32'h0B));
        vecs.push_back(mk(c_OP_REC,  1, 0, 20'h00500, 20'h00600, 0, 0));  // JALR filtered
        vecs.push_back(mk(c_OP_REC,  2, 0, 20'h00400, 20'h00480, 0, 0));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_TOS,       32'h2));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_FROM + 2,  32'h400));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_TO + 2,    32'h480));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_STATUS,    32'h3));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_CTRL,      32'h0B));
        vecs.push_back(mk(c_OP_WR,   0, 0, 0, 0, c_A_CTRL,      32'hFFFF_FFCF));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_CTRL,      32'h0F));
        vecs.push_back(mk(c_OP_REC,  3, 0, 20'h00700, 20'h00780, 0, 0));  // reserved type
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_STATUS,    32'h3));
        vecs.push_back(mk(c_OP_REC,  0, 1, 20'h00900, 20'h00980, 0, 0));  // stalled
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_TOS,       32'h2));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_STATUS,    32'h3));
        vecs.push_back(mk(c_OP_IDLE, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, c_A_FROM + 3,  32'h0));
        vecs.push_back(mk(c_OP_WR,   0, 0, 0, 0, 6'h23,         32'hFFFF));
        vecs.push_back(mk(c_OP_RD,   0, 0, 0, 0, 6'h23,         32'h0));

        // ---------------- reset ----------------
        repeat (3) step();
        reset = 1'b0;
        check("reset rdata",  csr_rdata, 32'h0);
        check("reset rvalid", 32'(csr_rvalid), 32'h0);
        check("reset irq",    32'(lbr_irq), 32'h0);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            case (vecs[i].op)
                c_OP_REC: begin
                    branch_valid = 1'b1;
                    branch_type  = vecs[i].bt;
                    stall        = vecs[i].st;
                    from_pc      = vecs[i].fpc;
                    to_pc        = vecs[i].tpc;
                end
                c_OP_WR: begin
                    csr_write = 1'b1;
                    csr_addr  = vecs[i].addr;
                    csr_wdata = vecs[i].dat;
                end
                c_OP_RD: begin
                    csr_read = 1'b1;
                    csr_addr = vecs[i].addr;
                end
                default: ;
            endcase
            step();
            clear_inputs();
            check($sformatf("vec%0d rvalid", i), 32'(csr_rvalid), 32'(vecs[i].op == c_OP_RD));
            if (vecs[i].op == c_OP_RD)
                check($sformatf("vec%0d rdata", i), csr_rdata, vecs[i].dat);
        end

        // ---------------- freeze on full + irq ----------------
        wr(c_A_STATUS, 32'h0);
        wr(c_A_TOS, 32'hF);
        wr(c_A_CTRL, 32'h3F);
        for (int k = 1; k <= 17; k++) begin
            rec(2'b00, 20'h01000 + 20'(k), 20'h02000 + 20'(k));
            if (k == 16) check("irq after 16th record", 32'(lbr_irq), 32'h0);
            if (k == 17) check("irq after 17th record", 32'(lbr_irq), 32'h1);
        end
        rd(c_A_TOS,        32'hF,       "freeze TOS");
        rd(c_A_STATUS,     32'h0003_0010, "freeze STATUS");
        rd(c_A_FROM + 15,  32'h1010,    "freeze FROM15");
        rd(c_A_FROM + 0,   32'h1001,    "freeze FROM0");
        rd(c_A_TO + 0,     32'h2001,    "freeze TO0");
        check("irq held", 32'(lbr_irq), 32'h1);
        wr(c_A_STATUS, 32'h0);
        check("irq on status-clear edge", 32'(lbr_irq), 32'h1);
        step();
        check("irq after status clear", 32'(lbr_irq), 32'h0);
        rd(c_A_STATUS, 32'h0, "cleared STATUS");

        // ---------------- wrap without freeze ----------------
        wr(c_A_CTRL, 32'h0F);
        for (int k = 1; k <= 20; k++) begin
            rec(2'b10, 20'h03000 + 20'(k), 20'h04000 + 20'(k));
        end
        rd(c_A_TOS,       32'h3,         "wrap TOS");
        rd(c_A_FROM + 0,  32'h3011,      "wrap FROM0");
        rd(c_A_FROM + 3,  32'h3014,      "wrap FROM3");
        rd(c_A_STATUS,    32'h0001_0010, "wrap STATUS");
        check("wrap irq disabled", 32'(lbr_irq), 32'h0);

        // ---------------- same-edge races ----------------
        branch_valid = 1'b1; branch_type = 2'b00; from_pc = 20'h04444; to_pc = 20'h05555;
        csr_write = 1'b1; csr_addr = c_A_TOS; csr_wdata = 32'h5;
        step(); clear_inputs();
        rd(c_A_TOS,      32'h5,    "race TOS write wins");
        rd(c_A_FROM + 4, 32'h4444, "race entry old_TOS+1");
        rd(c_A_TO + 4,   32'h5555, "race TO old_TOS+1");

        branch_valid = 1'b1; branch_type = 2'b00; from_pc = 20'h06666; to_pc = 20'h07777;
        csr_write = 1'b1; csr_addr = c_A_FROM + 6; csr_wdata = 32'hDEAD;
        step(); clear_inputs();
        rd(c_A_FROM + 6, 32'h6666, "collision record wins");
        rd(c_A_TOS,      32'h6,    "collision TOS");

        branch_valid = 1'b1; branch_type = 2'b00; from_pc = 20'h07070; to_pc = 20'h07171;
        csr_write = 1'b1; csr_addr = c_A_TO + 0; csr_wdata = 32'hBEEF;
        step(); clear_inputs();
        rd(c_A_TO + 0,   32'hBEEF, "restore TO0");
        rd(c_A_FROM + 7, 32'h7070, "record beside restore");

        branch_valid = 1'b1; branch_type = 2'b00; from_pc = 20'h08888; to_pc = 20'h09999;
        csr_write = 1'b1; csr_addr = c_A_STATUS; csr_wdata = 32'h0;
        step(); clear_inputs();
        rd(c_A_STATUS,   32'h0,    "status write wins");
        rd(c_A_TOS,      32'h8,    "status race TOS");

        csr_write = 1'b1; csr_read = 1'b1; csr_addr = c_A_CTRL; csr_wdata = 32'h07;
        step(); clear_inputs();
        check("write+read no rvalid", 32'(csr_rvalid), 32'h0);
        check("write+read rdata held", csr_rdata, 32'h8);
        rd(c_A_CTRL, 32'h07, "write+read CTRL");

        // ---------------- reset during a record ----------------
        wr(c_A_CTRL, 32'h0F);
        rd(c_A_FROM + 4, 32'h4444, "pre-reset FROM4");
        reset = 1'b1;
        branch_valid = 1'b1; branch_type = 2'b00; from_pc = 20'h00AAA; to_pc = 20'h00BBB;
        csr_write = 1'b1; csr_addr = c_A_CTRL; csr_wdata = 32'h3F;
        step();
        reset = 1'b0;
        clear_inputs();
        check("mid reset rdata",  csr_rdata, 32'h0);
        check("mid reset rvalid", 32'(csr_rvalid), 32'h0);
        check("mid reset irq",    32'(lbr_irq), 32'h0);
        rd(c_A_TOS,      32'hF,  "mid reset TOS");
        rd(c_A_CTRL,     32'h0F, "mid reset CTRL");
        rd(c_A_STATUS,   32'h0,  "mid reset STATUS");
        rd(c_A_FROM + 4, 32'h0,  "mid reset FROM4");
        rd(c_A_FROM + 0, 32'h0,  "mid reset FROM0");

        // ---------------- stamp window ----------------
        wr(c_A_STAMP + 2, 32'h1234);
`ifdef LBR_CYCLE_STAMP_EN
        rd(c_A_STAMP + 2, 32'h1234, "STAMP2 write");
`else
        rd(c_A_STAMP + 2, 32'h0, "STAMP2 absent");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
